// File: rtl/imem_boot_loader.sv
// imem_boot_loader: assembles a length-framed byte stream into ICCM words and flags completion.
// Optional trailing checksum word is compiled in when LOADER_CHECKSUM_EN is defined.
module imem_boot_loader #(
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned ADDR_WIDTH     = 12,
   parameter int unsigned NUM_SRC        = 2,
   parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
   localparam int unsigned SEL_W         = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic [SEL_W-1:0]        src_sel_i,
   input  logic [NUM_SRC-1:0]      rx_dv_i,
   input  logic [NUM_SRC*8-1:0]    rx_byte_i,
   input  logic                    restart_i,
   output logic                    we_o,
   output logic [ADDR_WIDTH-1:0]   addr_o,
   output logic [DATA_WIDTH-1:0]   wdata_o,
   output logic                    busy_o,
   output logic                    done_o,
   output logic                    err_o
);

   localparam int unsigned NB  = DATA_WIDTH / 8;
   localparam int unsigned BCW = (NB > 1) ? $clog2(NB) : 1;
   localparam int unsigned TCW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam int unsigned LW  = ADDR_WIDTH + 1;
   localparam logic [BCW-1:0] LAST_BYTE = BCW'(NB - 1);
   localparam logic [TCW-1:0] TO_LAST   = TCW'(TIMEOUT_CYCLES - 1);

   if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH < 8 || DATA_WIDTH > 64 || NUM_SRC < 1) begin : g_param_check
      $error("imem_boot_loader: unsupported DATA_WIDTH or NUM_SRC");
   end

   typedef enum logic [2:0] {
      S_IDLE,
      S_HDR,
      S_DATA,
`ifdef LOADER_CHECKSUM_EN
      S_CSUM,
`endif
      S_DONE,
      S_ERR
   } state_e;

   state_e                state_q;
   logic [SEL_W-1:0]      sel_q;
   logic [SEL_W-1:0]      sel;
   logic                  acc;
   logic [7:0]            byte_in;
   logic [BCW-1:0]        byte_cnt_q;
   logic [DATA_WIDTH-1:0] shreg_q;
   logic [DATA_WIDTH-1:0] word_nxt;
   logic                  word_end;
   logic [LW-1:0]         len_q;
   logic [LW-1:0]         wr_cnt_q;
   logic [TCW-1:0]        idle_q;
   logic [64:0]           len_ext;
   logic                  len_zero;
   logic                  len_too_big;
   logic                  in_frame;
`ifdef LOADER_CHECKSUM_EN
   logic [DATA_WIDTH-1:0] csum_q;
`endif

   always_comb begin
      sel     = (state_q == S_IDLE) ? src_sel_i : sel_q;
      acc     = 1'b0;
      byte_in = '0;
      for (int unsigned k = 0; k < NUM_SRC; k++) begin
         if (32'(sel) == k) begin
            acc     = rx_dv_i[k];
            byte_in = rx_byte_i[8*k +: 8];
         end
      end
      if (state_q == S_DONE || state_q == S_ERR) acc = 1'b0;
      in_frame    = (state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_ERR);
      // Bytes arrive LSB first, so each new byte enters at the top of the shift register.
      word_nxt    = (shreg_q >> 8) | (DATA_WIDTH'(byte_in) << (DATA_WIDTH - 8));
      word_end    = acc && (byte_cnt_q == LAST_BYTE);
      len_ext     = 65'(word_nxt);
      len_zero    = (word_nxt == '0);
      len_too_big = len_ext > (65'(1) << ADDR_WIDTH);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= S_IDLE;
         sel_q      <= '0;
         byte_cnt_q <= '0;
         shreg_q    <= '0;
         len_q      <= '0;
         wr_cnt_q   <= '0;
         idle_q     <= '0;
         we_o       <= 1'b0;
         addr_o     <= '0;
         wdata_o    <= '0;
         busy_o     <= 1'b0;
         done_o     <= 1'b0;
         err_o      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
         csum_q     <= '0;
`endif
      end else begin
         we_o <= 1'b0;
         if (acc) begin
            shreg_q    <= word_nxt;
            byte_cnt_q <= word_end ? '0 : byte_cnt_q + 1'b1;
         end

         // Idle watchdog; an accepted byte in the same cycle always wins.
         if (acc) begin
            idle_q <= '0;
         end else if (in_frame) begin
            if (idle_q == TO_LAST) begin
               state_q <= S_ERR;
               busy_o  <= 1'b0;
               err_o   <= 1'b1;
            end else begin
               idle_q <= idle_q + 1'b1;
            end
         end

         case (state_q)
            S_IDLE, S_HDR: begin
               if (acc && state_q == S_IDLE) sel_q <= src_sel_i;
               if (word_end) begin
                  len_q    <= LW'(word_nxt);
                  wr_cnt_q <= '0;
                  addr_o   <= '0;
                  if (len_zero) begin
`ifdef LOADER_CHECKSUM_EN
                     state_q <= S_CSUM;
                     busy_o  <= 1'b1;
`else
                     state_q <= S_DONE;
                     busy_o  <= 1'b0;
                     done_o  <= 1'b1;
`endif
                  end else if (len_too_big) begin
                     state_q <= S_ERR;
                     busy_o  <= 1'b0;
                     err_o   <= 1'b1;
                  end else begin
                     state_q <= S_DATA;
                     busy_o  <= 1'b1;
                  end
               end else if (acc) begin
                  state_q <= S_HDR;
                  busy_o  <= 1'b1;
               end
            end

            S_DATA: begin
               // addr_o trails wr_cnt_q by one cycle so it stays stable during the we_o pulse.
               addr_o <= wr_cnt_q[ADDR_WIDTH-1:0];
               if (word_end) begin
                  we_o     <= 1'b1;
                  wdata_o  <= word_nxt;
                  wr_cnt_q <= wr_cnt_q + 1'b1;
`ifdef LOADER_CHECKSUM_EN
                  csum_q   <= csum_q + word_nxt;
`endif
                  if (wr_cnt_q + 1'b1 == len_q) begin
`ifdef LOADER_CHECKSUM_EN
                     state_q <= S_CSUM;
`else
                     state_q <= S_DONE;
                     busy_o  <= 1'b0;
                     done_o  <= 1'b1;
`endif
                  end
               end
            end

`ifdef LOADER_CHECKSUM_EN
            S_CSUM: begin
               if (word_end) begin
                  busy_o <= 1'b0;
                  if (word_nxt == csum_q) begin
                     state_q <= S_DONE;
                     done_o  <= 1'b1;
                  end else begin
                     state_q <= S_ERR;
                     err_o   <= 1'b1;
                  end
               end
            end
`endif

            S_DONE, S_ERR: begin
               if (restart_i) begin
                  state_q    <= S_IDLE;
                  done_o     <= 1'b0;
                  err_o      <= 1'b0;
                  addr_o     <= '0;
                  byte_cnt_q <= '0;
                  wr_cnt_q   <= '0;
                  idle_q     <= '0;
`ifdef LOADER_CHECKSUM_EN
                  csum_q     <= '0;
`endif
               end
            end

            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule
